// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: PLL RESETB driver, lock filter/timeout supervisor and staged reset release
module pll_reset_sequencer #(
  parameter int NUM_RESETS     = 3,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_FILTER    = 256,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int STAGE_GAP      = 64,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pll_locked,
  input  logic                  soft_reset_req,
  output logic                  pll_resetb,
  output logic [NUM_RESETS-1:0] rst_out,
  output logic                  ready,
  output logic [CNT_WIDTH-1:0]  lock_loss_count,
  output logic [CNT_WIDTH-1:0]  timeout_count
);
  localparam int PW = $clog2(PLL_RST_CYCLES + 1);
  localparam int FW = $clog2(LOCK_FILTER + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int GW = $clog2(STAGE_GAP + 1);
  localparam int SW = (NUM_RESETS > 1) ? $clog2(NUM_RESETS) : 1;

  typedef enum logic [2:0] {PLL_RST, WAIT_LOCK, RELEASE, RUN, SOFT_HOLD} state_t;

  state_t                state_q, state_d;
  logic [1:0]            sync_q;
  logic [PW-1:0]         pcnt_q, pcnt_d;
  logic [FW-1:0]         filt_q, filt_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [SW-1:0]         stage_q, stage_d;
  logic [CNT_WIDTH-1:0]  llc_q, llc_d, tmc_q, tmc_d;
  logic [NUM_RESETS-1:0] rst_q, rst_d;
  logic                  pll_resetb_q, pll_resetb_d, ready_q, ready_d;
  logic                  lock_s;

  assign lock_s          = sync_q[1];
  assign pll_resetb      = pll_resetb_q;
  assign rst_out         = rst_q;
  assign ready           = ready_q;
  assign lock_loss_count = llc_q;
  assign timeout_count   = tmc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= PLL_RST;
      sync_q       <= '0;
      pcnt_q       <= '0;
      filt_q       <= '0;
      tmo_q        <= '0;
      gap_q        <= '0;
      stage_q      <= '0;
      llc_q        <= '0;
      tmc_q        <= '0;
      rst_q        <= '1;
      pll_resetb_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= {sync_q[0], pll_locked};
      pcnt_q       <= pcnt_d;
      filt_q       <= filt_d;
      tmo_q        <= tmo_d;
      gap_q        <= gap_d;
      stage_q      <= stage_d;
      llc_q        <= llc_d;
      tmc_q        <= tmc_d;
      rst_q        <= rst_d;
      pll_resetb_q <= pll_resetb_d;
      ready_q      <= ready_d;
    end
  end

  // Per-state counters idle at zero outside their own state, so every entry starts clean.
  always_comb begin
    state_d = state_q;
    pcnt_d  = '0;
    filt_d  = '0;
    tmo_d   = '0;
    gap_d   = '0;
    stage_d = stage_q;
    llc_d   = llc_q;
    tmc_d   = tmc_q;
    case (state_q)
      PLL_RST: begin
        if (pcnt_q == PW'(PLL_RST_CYCLES - 1)) state_d = WAIT_LOCK;
        else pcnt_d = pcnt_q + PW'(1);
      end
      WAIT_LOCK: begin
        if (lock_s && filt_q == FW'(LOCK_FILTER - 1)) begin
          state_d = RELEASE;
          stage_d = '0;
        end else if (tmo_q == TW'(LOCK_TIMEOUT - 1)) begin
          state_d = PLL_RST;
          tmc_d   = (tmc_q == '1) ? tmc_q : tmc_q + CNT_WIDTH'(1);
        end else begin
          filt_d = lock_s ? filt_q + FW'(1) : '0;
          tmo_d  = tmo_q + TW'(1);
        end
      end
      RELEASE: begin
        if (!lock_s) state_d = PLL_RST;
        else if (gap_q != GW'(STAGE_GAP - 1)) gap_d = gap_q + GW'(1);
        else if (stage_q == SW'(NUM_RESETS - 1)) state_d = RUN;
        else stage_d = stage_q + SW'(1);
      end
      RUN: begin
        if (!lock_s) begin
          state_d = PLL_RST;
          llc_d   = (llc_q == '1) ? llc_q : llc_q + CNT_WIDTH'(1);
        end else if (soft_reset_req) state_d = SOFT_HOLD;
      end
      SOFT_HOLD: begin
        if (!lock_s) state_d = PLL_RST;
        else if (gap_q != GW'(STAGE_GAP - 1)) gap_d = gap_q + GW'(1);
        else begin
          state_d = RELEASE;
          stage_d = '0;
        end
      end
      default: state_d = PLL_RST;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    pll_resetb_d = state_d != PLL_RST;
    ready_d      = state_d == RUN;
    rst_d        = '1;
    for (int i = 0; i < NUM_RESETS; i++)
      rst_d[i] = (state_d == RUN) ? 1'b0 : (state_d == RELEASE) ? (SW'(i) > stage_d) : 1'b1;
  end
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed scenario bench for the PLL supervisor and staged reset release
module tb_pll_reset_sequencer;
  logic       clk = 1'b0, reset = 1'b1, pll_locked = 1'b0, soft_reset_req = 1'b0;
  logic       pll_resetb, ready;
  logic [2:0] rst_out;
  logic [3:0] lock_loss_count, timeout_count;
  int         n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .NUM_RESETS(3), .PLL_RST_CYCLES(4), .LOCK_FILTER(8),
    .LOCK_TIMEOUT(32), .STAGE_GAP(5), .CNT_WIDTH(4)
  ) dut (
    .clk(clk), .reset(reset), .pll_locked(pll_locked), .soft_reset_req(soft_reset_req),
    .pll_resetb(pll_resetb), .rst_out(rst_out), .ready(ready),
    .lock_loss_count(lock_loss_count), .timeout_count(timeout_count)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; pll_locked = 1'b1; soft_reset_req = 1'b0;
    step(3);
    n_checks++; if (pll_resetb !== 1'b0) begin n_fail++; $display("FAIL rst_pll_resetb got %b want 0", pll_resetb); end
    n_checks++; if (rst_out !== 3'b111) begin n_fail++; $display("FAIL rst_rst_out got %b want 111", rst_out); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b want 0", ready); end
    n_checks++; if (lock_loss_count !== 4'd0) begin n_fail++; $display("FAIL rst_llc got %0d want 0", lock_loss_count); end
    n_checks++; if (timeout_count !== 4'd0) begin n_fail++; $display("FAIL rst_tmc got %0d want 0", timeout_count); end
    reset = 1'b0;
  endtask

  task automatic test_cold_boot;
    int k;
    k = 0; do begin step(1); k++; end while (pll_resetb === 1'b0 && k < 64);
    n_checks++; if (k !== 4) begin n_fail++; $display("FAIL cold_resetb_low got %0d want 4", k); end
    k = 0; do begin step(1); k++; end while (rst_out === 3'b111 && k < 64);
    n_checks++; if (k !== 8) begin n_fail++; $display("FAIL cold_rel0_delay got %0d want 8", k); end
    n_checks++; if (rst_out !== 3'b110) begin n_fail++; $display("FAIL cold_rel0 got %b want 110", rst_out); end
    k = 0; do begin step(1); k++; end while (rst_out === 3'b110 && k < 64);
    n_checks++; if (k !== 5 || rst_out !== 3'b100) begin n_fail++; $display("FAIL cold_rel1 got %0d/%b want 5/100", k, rst_out); end
    k = 0; do begin step(1); k++; end while (rst_out === 3'b100 && k < 64);
    n_checks++; if (k !== 5 || rst_out !== 3'b000) begin n_fail++; $display("FAIL cold_rel2 got %0d/%b want 5/000", k, rst_out); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL cold_ready_early got %b want 0", ready); end
    k = 0; do begin step(1); k++; end while (ready !== 1'b1 && k < 64);
    n_checks++; if (k !== 5) begin n_fail++; $display("FAIL cold_ready_delay got %0d want 5", k); end
    n_checks++; if (pll_resetb !== 1'b1) begin n_fail++; $display("FAIL cold_run_resetb got %b want 1", pll_resetb); end
  endtask

  task automatic test_glitchy_lock;
    int k;
    logic bad;
    reset = 1'b1; pll_locked = 1'b0;
    step(2);
    reset = 1'b0; bad = 1'b0;
    for (int i = 0; i < 24; i++) begin
      pll_locked = (i % 6) != 5;
      step(1);
      if (rst_out !== 3'b111) bad = 1'b1;
    end
    pll_locked = 1'b1;
    n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL glitch_hold got early release want none"); end
    k = 0; do begin step(1); k++; end while (rst_out === 3'b111 && k < 64);
    n_checks++; if (k !== 10) begin n_fail++; $display("FAIL glitch_release_delay got %0d want 10", k); end
    n_checks++; if (timeout_count !== 4'd0) begin n_fail++; $display("FAIL glitch_tmc got %0d want 0", timeout_count); end
    k = 0; do begin step(1); k++; end while (ready !== 1'b1 && k < 64);
    n_checks++; if (k !== 15) begin n_fail++; $display("FAIL glitch_ready_delay got %0d want 15", k); end
  endtask

  task automatic test_lock_loss_run;
    int k;
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL loss_lat1 got %b want 1", ready); end
    step(1);
    n_checks++; if (ready !== 1'b1 || rst_out !== 3'b000) begin n_fail++; $display("FAIL loss_lat2 got %b/%b want 1/000", ready, rst_out); end
    step(1);
    n_checks++; if (rst_out !== 3'b111) begin n_fail++; $display("FAIL loss_rst_out got %b want 111", rst_out); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL loss_ready got %b want 0", ready); end
    n_checks++; if (lock_loss_count !== 4'd1) begin n_fail++; $display("FAIL loss_llc got %0d want 1", lock_loss_count); end
    n_checks++; if (pll_resetb !== 1'b0) begin n_fail++; $display("FAIL loss_resetb got %b want 0", pll_resetb); end
    k = 0; do begin step(1); k++; end while (pll_resetb === 1'b0 && k < 64);
    n_checks++; if (k !== 4) begin n_fail++; $display("FAIL loss_resetb_low got %0d want 4", k); end
    k = 0; do begin step(1); k++; end while (ready !== 1'b1 && k < 64);
    n_checks++; if (k !== 23) begin n_fail++; $display("FAIL loss_resequence got %0d want 23", k); end
    n_checks++; if (lock_loss_count !== 4'd1) begin n_fail++; $display("FAIL loss_llc_hold got %0d want 1", lock_loss_count); end
  endtask

  task automatic test_soft_reset;
    int k;
    soft_reset_req = 1'b1;
    step(1);
    soft_reset_req = 1'b0;
    n_checks++; if (rst_out !== 3'b111 || ready !== 1'b0) begin n_fail++; $display("FAIL soft_hold got %b/%b want 111/0", rst_out, ready); end
    n_checks++; if (pll_resetb !== 1'b1) begin n_fail++; $display("FAIL soft_resetb got %b want 1", pll_resetb); end
    k = 0; do begin step(1); k++; end while (rst_out === 3'b111 && k < 64);
    n_checks++; if (k !== 5 || rst_out !== 3'b110) begin n_fail++; $display("FAIL soft_release got %0d/%b want 5/110", k, rst_out); end
    soft_reset_req = 1'b1;
    step(1);
    soft_reset_req = 1'b0;
    n_checks++; if (rst_out !== 3'b110) begin n_fail++; $display("FAIL soft_ignored got %b want 110", rst_out); end
    k = 0; do begin step(1); k++; end while (rst_out === 3'b110 && k < 64);
    n_checks++; if (k !== 4 || rst_out !== 3'b100) begin n_fail++; $display("FAIL soft_rel1 got %0d/%b want 4/100", k, rst_out); end
    k = 0; do begin step(1); k++; end while (ready !== 1'b1 && k < 64);
    n_checks++; if (k !== 10) begin n_fail++; $display("FAIL soft_ready got %0d want 10", k); end
    n_checks++; if (lock_loss_count !== 4'd1) begin n_fail++; $display("FAIL soft_llc got %0d want 1", lock_loss_count); end
  endtask

  task automatic test_simultaneous;
    int k;
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(1);
    soft_reset_req = 1'b1;
    step(1);
    soft_reset_req = 1'b0;
    n_checks++; if (pll_resetb !== 1'b0 || rst_out !== 3'b111) begin n_fail++; $display("FAIL simul_state got %b/%b want 0/111", pll_resetb, rst_out); end
    n_checks++; if (lock_loss_count !== 4'd2) begin n_fail++; $display("FAIL simul_llc got %0d want 2", lock_loss_count); end
    k = 0; do begin step(1); k++; end while (ready !== 1'b1 && k < 64);
    n_checks++; if (k !== 27) begin n_fail++; $display("FAIL simul_resequence got %0d want 27", k); end
  endtask

  task automatic test_lock_timeout;
    logic bad;
    pll_locked = 1'b0;
    step(3);
    n_checks++; if (lock_loss_count !== 4'd3 || pll_resetb !== 1'b0) begin n_fail++; $display("FAIL tmo_entry got %0d/%b want 3/0", lock_loss_count, pll_resetb); end
    step(35);
    n_checks++; if (timeout_count !== 4'd0 || pll_resetb !== 1'b1) begin n_fail++; $display("FAIL tmo_before got %0d/%b want 0/1", timeout_count, pll_resetb); end
    step(1);
    n_checks++; if (timeout_count !== 4'd1 || pll_resetb !== 1'b0) begin n_fail++; $display("FAIL tmo_first got %0d/%b want 1/0", timeout_count, pll_resetb); end
    bad = 1'b0;
    for (int n = 2; n <= 17; n++) begin
      step(36);
      if (rst_out !== 3'b111) bad = 1'b1;
      n_checks++;
      if (timeout_count !== 4'((n > 15) ? 15 : n)) begin n_fail++; $display("FAIL tmo_count_%0d got %0d want %0d", n, timeout_count, (n > 15) ? 15 : n); end
    end
    n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL tmo_rst_out got release want 111"); end
    n_checks++; if (lock_loss_count !== 4'd3) begin n_fail++; $display("FAIL tmo_llc got %0d want 3", lock_loss_count); end
  endtask

  task automatic test_mid_reset;
    int k;
    pll_locked = 1'b1;
    k = 0; do begin step(1); k++; end while (rst_out === 3'b111 && k < 64);
    n_checks++; if (k !== 12 || rst_out !== 3'b110) begin n_fail++; $display("FAIL mid_release got %0d/%b want 12/110", k, rst_out); end
    n_checks++; if (timeout_count !== 4'd15) begin n_fail++; $display("FAIL mid_tmc_sat got %0d want 15", timeout_count); end
    step(2);
    reset = 1'b1;
    step(1);
    n_checks++; if (pll_resetb !== 1'b0 || rst_out !== 3'b111 || ready !== 1'b0) begin n_fail++; $display("FAIL mid_outputs got %b/%b/%b want 0/111/0", pll_resetb, rst_out, ready); end
    n_checks++; if (lock_loss_count !== 4'd0 || timeout_count !== 4'd0) begin n_fail++; $display("FAIL mid_counters got %0d/%0d want 0/0", lock_loss_count, timeout_count); end
    reset = 1'b0;
    step(1);
  endtask

  initial begin
    test_reset;
    test_cold_boot;
    test_glitchy_lock;
    test_lock_loss_run;
    test_soft_reset;
    test_simultaneous;
    test_lock_timeout;
    test_mid_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
